// File: rtl/cr_tcipif_pkg.sv
// ---------------------------------------------------------------------------
// cr_tcipif_pkg
// Shared definitions for the TCIP interface initiator and the CLINT side:
//   - state_e       : initiator FSM states (IDLE / ACCESS / RESP)
//   - CLINT_BASE_HI : address bits [31:16] of the 64 KB CLINT window
//   - CLINT register offsets inside that window
// ---------------------------------------------------------------------------
package cr_tcipif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [15:0] CLINT_BASE_HI = 16'hE000;

  localparam logic [15:0] MSIP        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI    = 16'hBFFC;

endpackage

// File: rtl/cr_tcipif_timeout.sv
// ---------------------------------------------------------------------------
// cr_tcipif_timeout
// Completion-timeout counter for the TCIP initiator. Counts cycles spent
// waiting for the CLINT and raises expire once TIMEOUT-1 has been reached.
// Ports:
//   clk    : clock (forever_cpuclk domain)
//   rst    : synchronous active-high reset
//   clear  : restart the count from 0 (wins over enable)
//   enable : advance the count by one this cycle
//   expire : count has reached TIMEOUT-1
// ---------------------------------------------------------------------------
module cr_tcipif_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Holding at LAST keeps the counter from wrapping even if the owner keeps
  // enable high after expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/cr_tcipif_initiator.sv
// ---------------------------------------------------------------------------
// cr_tcipif_initiator
// Initiator end of the TCIP interface. Takes single load/store requests from
// the LSU, decodes them against the CLINT window, runs one tcipif access with
// a completion timeout and hands back read data or an error.
// Ports:
//   forever_cpuclk / cpurst          : clock, synchronous active-high reset
//   lsu_tcip_req_*  / lsu_tcip_addr,
//   lsu_tcip_write / lsu_tcip_wdata  : LSU request channel (vld/rdy)
//   tcip_lsu_resp_* / tcip_lsu_rdata,
//   lsu_tcip_resp_rdy                : LSU response channel (vld/rdy)
//   tcipif_clint_*                   : select, offset, write strobe, data
//   clint_tcipif_cmplt / _rdata      : completion and read data from CLINT
// ---------------------------------------------------------------------------
module cr_tcipif_initiator #(
  parameter logic [15:0] CLINT_BASE_HI = cr_tcipif_pkg::CLINT_BASE_HI,
  parameter int          TIMEOUT       = 16
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        lsu_tcip_req_vld,
  output logic        lsu_tcip_req_rdy,
  input  logic [31:0] lsu_tcip_addr,
  input  logic        lsu_tcip_write,
  input  logic [31:0] lsu_tcip_wdata,
  output logic        tcip_lsu_resp_vld,
  output logic        tcip_lsu_resp_err,
  output logic [31:0] tcip_lsu_rdata,
  input  logic        lsu_tcip_resp_rdy,
  output logic        tcipif_clint_sel,
  output logic [15:0] tcipif_clint_addr,
  output logic        tcipif_clint_write,
  output logic [31:0] tcipif_clint_wdata,
  input  logic        clint_tcipif_cmplt,
  input  logic [31:0] clint_tcipif_rdata
);

  import cr_tcipif_pkg::*;

  state_e      state;
  state_e      state_next;

  logic [15:0] addr_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        decode_hit;
  logic        tmo_clear;
  logic        tmo_enable;
  logic        tmo_expire;

  // Only word-aligned accesses inside the 64 KB window reach the bus.
  assign decode_hit = (lsu_tcip_addr[31:16] == CLINT_BASE_HI) &&
                      (lsu_tcip_addr[1:0] == 2'b00);

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Completion is checked before expiry so a cmplt arriving on the last
  // allowed cycle still produces a normal response.
  always_comb begin
    state_next        = state;
    lsu_tcip_req_rdy  = 1'b0;
    tcipif_clint_sel  = 1'b0;
    tcip_lsu_resp_vld = 1'b0;
    tmo_clear         = 1'b0;
    tmo_enable        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        lsu_tcip_req_rdy = 1'b1;
        if (lsu_tcip_req_vld) begin
          if (decode_hit) begin
            state_next = ST_ACCESS;
            tmo_clear  = 1'b1;
          end else begin
            state_next = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        tcipif_clint_sel = 1'b1;
        if (clint_tcipif_cmplt || tmo_expire) begin
          state_next = ST_RESP;
        end else begin
          tmo_enable = 1'b1;
        end
      end
      ST_RESP: begin
        tcip_lsu_resp_vld = 1'b1;
        if (lsu_tcip_resp_rdy) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Request latch and response registers. A decode miss loads the error
  // response directly at accept time, so no bus cycle is spent on it.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (state == ST_IDLE && lsu_tcip_req_vld) begin
        addr_q  <= lsu_tcip_addr[15:0];
        write_q <= lsu_tcip_write;
        wdata_q <= lsu_tcip_wdata;
        err_q   <= !decode_hit;
        rdata_q <= '0;
      end else if (state == ST_ACCESS) begin
        if (clint_tcipif_cmplt) begin
          err_q   <= 1'b0;
          rdata_q <= write_q ? 32'h0 : clint_tcipif_rdata;
        end else if (tmo_expire) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
      end
    end
  end

  cr_tcipif_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (forever_cpuclk),
    .rst    (cpurst),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expire (tmo_expire)
  );

  // Bus and response fields are forced to 0 outside their owning state so
  // that stale latch contents never leak onto either interface.
  assign tcipif_clint_addr  = tcipif_clint_sel ? addr_q  : 16'h0;
  assign tcipif_clint_write = tcipif_clint_sel ? write_q : 1'b0;
  assign tcipif_clint_wdata = tcipif_clint_sel ? wdata_q : 32'h0;
  assign tcip_lsu_resp_err  = tcip_lsu_resp_vld ? err_q   : 1'b0;
  assign tcip_lsu_rdata     = tcip_lsu_resp_vld ? rdata_q : 32'h0;

endmodule

// File: tb/tb_cr_tcipif_initiator.sv
// ---------------------------------------------------------------------------
// tb_cr_tcipif_initiator
// Bench for cr_tcipif_initiator. The bench plays both the LSU and the CLINT,
// predicts each transaction outcome from the address, direction, CLINT
// completion delay and response backpressure, and compares the DUT against it.
// ---------------------------------------------------------------------------
module tb_cr_tcipif_initiator;

  import cr_tcipif_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int NEVER   = 1000;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst;
  logic        lsu_tcip_req_vld;
  logic        lsu_tcip_req_rdy;
  logic [31:0] lsu_tcip_addr;
  logic        lsu_tcip_write;
  logic [31:0] lsu_tcip_wdata;
  logic        tcip_lsu_resp_vld;
  logic        tcip_lsu_resp_err;
  logic [31:0] tcip_lsu_rdata;
  logic        lsu_tcip_resp_rdy;
  logic        tcipif_clint_sel;
  logic [15:0] tcipif_clint_addr;
  logic        tcipif_clint_write;
  logic [31:0] tcipif_clint_wdata;
  logic        clint_tcipif_cmplt;
  logic [31:0] clint_tcipif_rdata;

  int checks = 0;
  int errors = 0;

  logic [15:0] offsets [5] = '{MSIP, MTIMECMP_LO, MTIMECMP_HI, MTIME_LO, MTIME_HI};

  cr_tcipif_initiator #(
    .CLINT_BASE_HI (16'hE000),
    .TIMEOUT       (TIMEOUT)
  ) dut (
    .forever_cpuclk     (forever_cpuclk),
    .cpurst             (cpurst),
    .lsu_tcip_req_vld   (lsu_tcip_req_vld),
    .lsu_tcip_req_rdy   (lsu_tcip_req_rdy),
    .lsu_tcip_addr      (lsu_tcip_addr),
    .lsu_tcip_write     (lsu_tcip_write),
    .lsu_tcip_wdata     (lsu_tcip_wdata),
    .tcip_lsu_resp_vld  (tcip_lsu_resp_vld),
    .tcip_lsu_resp_err  (tcip_lsu_resp_err),
    .tcip_lsu_rdata     (tcip_lsu_rdata),
    .lsu_tcip_resp_rdy  (lsu_tcip_resp_rdy),
    .tcipif_clint_sel   (tcipif_clint_sel),
    .tcipif_clint_addr  (tcipif_clint_addr),
    .tcipif_clint_write (tcipif_clint_write),
    .tcipif_clint_wdata (tcipif_clint_wdata),
    .clint_tcipif_cmplt (clint_tcipif_cmplt),
    .clint_tcipif_rdata (clint_tcipif_rdata)
  );

  // Free-running 10-time-unit clock.
  always #5 forever_cpuclk = ~forever_cpuclk;

  // One comparison: bumps the check count, and on a miss the error count.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge forever_cpuclk);
    #1;
  endtask

  // Run one full transaction. delay is the sel cycle (1-based) on which the
  // CLINT completes; bp is the number of RESP cycles with resp_rdy held low.
  task automatic applyStimulus(input logic [31:0] addr, input logic write,
                               input logic [31:0] wdata, input int delay,
                               input logic [31:0] crdata, input int bp);
    logic        mapped;
    int          exp_sel;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          cyc;

    mapped    = (addr[31:16] == 16'hE000) && (addr[1:0] == 2'b00);
    exp_sel   = !mapped ? 0 : ((delay < TIMEOUT) ? delay : TIMEOUT);
    exp_err   = !mapped || (delay > TIMEOUT);
    exp_rdata = (exp_err || write) ? 32'h0 : crdata;

    checkOutput("req_rdy_idle", 32'(lsu_tcip_req_rdy), 32'd1);
    lsu_tcip_req_vld = 1'b1;
    lsu_tcip_addr    = addr;
    lsu_tcip_write   = write;
    lsu_tcip_wdata   = wdata;
    tick();
    lsu_tcip_req_vld = 1'b0;
    lsu_tcip_addr    = $urandom;
    lsu_tcip_write   = 1'($urandom_range(0, 1));
    lsu_tcip_wdata   = $urandom;

    cyc = 0;
    while (tcipif_clint_sel === 1'b1 && cyc < 100) begin
      cyc++;
      checkOutput("bus_addr", 32'(tcipif_clint_addr), 32'(addr[15:0]));
      checkOutput("bus_write", 32'(tcipif_clint_write), 32'(write));
      checkOutput("bus_wdata", tcipif_clint_wdata, wdata);
      checkOutput("req_rdy_access", 32'(lsu_tcip_req_rdy), 32'd0);
      checkOutput("resp_vld_access", 32'(tcip_lsu_resp_vld), 32'd0);
      clint_tcipif_cmplt = (cyc == delay);
      clint_tcipif_rdata = (cyc == delay) ? crdata : $urandom;
      tick();
    end
    clint_tcipif_cmplt = 1'($urandom_range(0, 1));
    clint_tcipif_rdata = $urandom;

    checkOutput("sel_cycles", 32'(cyc), 32'(exp_sel));
    checkOutput("resp_vld", 32'(tcip_lsu_resp_vld), 32'd1);
    checkOutput("resp_err", 32'(tcip_lsu_resp_err), 32'(exp_err));
    checkOutput("resp_rdata", tcip_lsu_rdata, exp_rdata);

    // Backpressure: a pending request must not be taken while in RESP.
    for (int i = 0; i < bp; i++) begin
      lsu_tcip_resp_rdy = 1'b0;
      lsu_tcip_req_vld  = 1'b1;
      lsu_tcip_addr     = 32'hE000_0000;
      tick();
      checkOutput("bp_resp_vld", 32'(tcip_lsu_resp_vld), 32'd1);
      checkOutput("bp_resp_err", 32'(tcip_lsu_resp_err), 32'(exp_err));
      checkOutput("bp_resp_rdata", tcip_lsu_rdata, exp_rdata);
      checkOutput("bp_req_rdy", 32'(lsu_tcip_req_rdy), 32'd0);
      checkOutput("bp_sel", 32'(tcipif_clint_sel), 32'd0);
    end
    lsu_tcip_resp_rdy = 1'b1;
    tick();
    lsu_tcip_resp_rdy = 1'b0;
    lsu_tcip_req_vld  = 1'b0;
    checkOutput("post_resp_vld", 32'(tcip_lsu_resp_vld), 32'd0);
    checkOutput("post_req_rdy", 32'(lsu_tcip_req_rdy), 32'd1);
    checkOutput("post_sel", 32'(tcipif_clint_sel), 32'd0);
  endtask

  // Directed test plan followed by randomized transactions.
  initial begin
    logic [31:0] r;
    logic [31:0] a;
    int          kind;

    cpurst             = 1'b1;
    lsu_tcip_req_vld   = 1'b0;
    lsu_tcip_addr      = '0;
    lsu_tcip_write     = 1'b0;
    lsu_tcip_wdata     = '0;
    lsu_tcip_resp_rdy  = 1'b0;
    clint_tcipif_cmplt = 1'b0;
    clint_tcipif_rdata = '0;
    tick();
    tick();
    checkOutput("rst_sel", 32'(tcipif_clint_sel), 32'd0);
    checkOutput("rst_resp_vld", 32'(tcip_lsu_resp_vld), 32'd0);
    checkOutput("rst_req_rdy", 32'(lsu_tcip_req_rdy), 32'd1);
    checkOutput("rst_err", 32'(tcip_lsu_resp_err), 32'd0);
    checkOutput("rst_rdata", tcip_lsu_rdata, 32'd0);
    checkOutput("rst_addr", 32'(tcipif_clint_addr), 32'd0);
    cpurst = 1'b0;
    tick();

    $display("[TB] directed: store, slow load, decode errors, timeout");
    applyStimulus(32'hE000_4000, 1'b1, 32'h0000_1234, 1, 32'hDEAD_BEEF, 0);
    applyStimulus(32'hE000_0000, 1'b0, 32'h0, 3, 32'h0000_0001, 0);
    applyStimulus(32'h2000_0000, 1'b0, 32'h0, 1, 32'h5555_5555, 0);
    applyStimulus(32'hE000_0002, 1'b0, 32'h0, 1, 32'h5555_5555, 0);
    applyStimulus(32'hE000_BFF8, 1'b0, 32'h0, NEVER, 32'h1111_1111, 0);
    applyStimulus(32'hE000_BFF8, 1'b0, 32'h0, TIMEOUT, 32'h0000_00AA, 0);
    applyStimulus(32'hE000_BFFC, 1'b0, 32'h0, 2, 32'h1357_9BDF, 5);

    $display("[TB] directed: reset during access");
    clint_tcipif_cmplt = 1'b0;
    lsu_tcip_req_vld   = 1'b1;
    lsu_tcip_addr      = 32'hE000_4004;
    lsu_tcip_write     = 1'b0;
    tick();
    lsu_tcip_req_vld = 1'b0;
    checkOutput("rstx_sel_c1", 32'(tcipif_clint_sel), 32'd1);
    tick();
    checkOutput("rstx_sel_c2", 32'(tcipif_clint_sel), 32'd1);
    cpurst = 1'b1;
    tick();
    cpurst = 1'b0;
    checkOutput("rstx_sel", 32'(tcipif_clint_sel), 32'd0);
    checkOutput("rstx_resp_vld", 32'(tcip_lsu_resp_vld), 32'd0);
    checkOutput("rstx_req_rdy", 32'(lsu_tcip_req_rdy), 32'd1);
    tick();
    checkOutput("rstx_resp_vld2", 32'(tcip_lsu_resp_vld), 32'd0);
    applyStimulus(32'hE000_4004, 1'b0, 32'h0, 1, 32'hCAFE_F00D, 1);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 40; n++) begin
      r    = $urandom;
      kind = $urandom_range(0, 5);
      if (kind <= 2) begin
        a = {16'hE000, offsets[$urandom_range(0, 4)]};
      end else if (kind == 3) begin
        a = {16'h2000 + 16'(r[3:0]), r[31:16]};
      end else if (kind == 4) begin
        a = {16'hE000, r[15:2], 2'b01 + 2'(r[17:16] % 3)};
      end else begin
        a = {16'hE000, r[15:2], 2'b00};
      end
      applyStimulus(a, 1'($urandom_range(0, 1)), $urandom,
                    $urandom_range(1, 20), $urandom, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
